// File: rtl/edge_detector_multi.sv
// Multi-channel edge detector.
// Each channel has an optional synchroniser chain and debounce filter, a runtime
// edge mode (00 off, 01 rise, 10 fall, 11 both), a one-cycle pulse and a sticky flag.
// Define EDGE_CNT_EN to add a saturating per-channel event counter; without it cnt_o is 0.
// A commit is registered once (with the mode applied) before it drives pulse_o. So pulse_o
// rises SYNC_STAGES + max(FILT_LEN,1) cycles after the first edge that samples a new level.
module edge_detector_multi #(
    parameter int unsigned CH          = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 0,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CH-1:0]       sig_i,
    input  logic [2*CH-1:0]     mode_i,
    input  logic [CH-1:0]       clr_i,
    output logic [CH-1:0]       pulse_o,
    output logic [CH-1:0]       sticky_o,
    output logic [CH*CNT_W-1:0] cnt_o
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic s;          // synchronised input
        logic f_q, f_d;   // filtered level
        logic commit;     // filtered level changes this cycle
        logic det_d, det_q;
        logic pulse_q, sticky_q;

        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = sig_i[i];
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            // Shift the raw input through the synchroniser chain
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= sig_i[i];
                    for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end

        if (FILT_LEN >= 2) begin : g_filt
            localparam int unsigned    FcW    = $clog2(FILT_LEN);
            localparam logic [FcW-1:0] FcLast = FcW'(FILT_LEN - 1);

            logic [FcW-1:0] fc_q, fc_d;

            // Count consecutive disagreeing samples; flip f on the FILT_LEN-th one
            always_comb begin
                fc_d   = '0;
                f_d    = f_q;
                commit = 1'b0;
                if (s != f_q) begin
                    if (fc_q == FcLast) begin
                        f_d    = ~f_q;
                        commit = 1'b1;
                    end else begin
                        fc_d = fc_q + 1'b1;
                    end
                end
            end

            // Debounce counter state
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    fc_q <= '0;
                end else begin
                    fc_q <= fc_d;
                end
            end
        end else begin : g_nofilt
            // No debounce: the filtered level follows the synchronised input
            always_comb begin
                f_d    = s;
                commit = s ^ f_q;
            end
        end

        // Mode is applied at the commit cycle: bit 0 enables rise, bit 1 enables fall
        always_comb begin
            det_d = commit & (f_d ? mode_i[2*i] : mode_i[2*i+1]);
        end

        // Filtered level, detection stage, output pulse and sticky flag (set beats clear)
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                f_q      <= 1'b0;
                det_q    <= 1'b0;
                pulse_q  <= 1'b0;
                sticky_q <= 1'b0;
            end else begin
                f_q      <= f_d;
                det_q    <= det_d;
                pulse_q  <= det_q;
                sticky_q <= det_q | (sticky_q & ~clr_i[i]);
            end
        end

        assign pulse_o[i]  = pulse_q;
        assign sticky_o[i] = sticky_q;

`ifdef EDGE_CNT_EN
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // Saturating event count; a clear coinciding with an event restarts at one
        always_comb begin
            cnt_d = cnt_q;
            if (clr_i[i]) begin
                cnt_d = det_q ? CNT_W'(1) : '0;
            end else if (det_q && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Event counter state
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt_o[i*CNT_W +: CNT_W] = cnt_q;
`else
        assign cnt_o[i*CNT_W +: CNT_W] = '0;
`endif
    end

endmodule

// File: tb/tb_edge_detector_multi.sv
// Bench for edge_detector_multi: two instances share one stimulus stream,
// A (no sync, no filter) and B (2 sync stages, 4-cycle debounce), CNT_W=2.
// A behavioural model predicts pulse/sticky/cnt each cycle; directed steps add fixed checks.
module tb_edge_detector_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] sig = 4'h0;
    logic [7:0] mode = 8'h00;
    logic [3:0] clr = 4'h0;
    logic [3:0] pulse_a, sticky_a, pulse_b, sticky_b;
    logic [7:0] cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;

`ifdef EDGE_CNT_EN
    localparam bit CntOn = 1'b1;
`else
    localparam bit CntOn = 1'b0;
`endif

    always #5 clk = ~clk;

    edge_detector_multi #(.CH(4), .SYNC_STAGES(0), .FILT_LEN(0), .CNT_W(2)) u_a (
        .clk_i(clk), .rst_i(rst), .sig_i(sig), .mode_i(mode), .clr_i(clr),
        .pulse_o(pulse_a), .sticky_o(sticky_a), .cnt_o(cnt_a)
    );

    edge_detector_multi #(.CH(4), .SYNC_STAGES(2), .FILT_LEN(4), .CNT_W(2)) u_b (
        .clk_i(clk), .rst_i(rst), .sig_i(sig), .mode_i(mode), .clr_i(clr),
        .pulse_o(pulse_b), .sticky_o(sticky_b), .cnt_o(cnt_b)
    );

    // Reference model: instance d in {0:A, 1:B}, channel c
    int         cfg_sync [2] = '{0, 2};
    int         cfg_len  [2] = '{0, 4};
    logic [3:0] samp[$];        // sig values sampled at earlier edges since reset
    bit         lvl  [2][4];    // filtered level
    int         run  [2][4];    // consecutive samples disagreeing with lvl
    bit         pend [2][4];    // enabled edge committed, pulse due next edge
    bit         ep   [2][4];
    bit         es   [2][4];
    int         ec   [2][4];

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
                bit s;
                bit p;
                bit commit;
                int need;
                if (rst) begin
                    lvl[d][c] = 0; run[d][c] = 0; pend[d][c] = 0;
                    ep[d][c] = 0; es[d][c] = 0; ec[d][c] = 0;
                    continue;
                end
                p = pend[d][c];
                ep[d][c] = p;
                if (p) es[d][c] = 1;
                else if (clr[c]) es[d][c] = 0;
                if (CntOn) begin
                    if (clr[c]) ec[d][c] = p ? 1 : 0;
                    else if (p && ec[d][c] < 3) ec[d][c]++;
                end
                if (cfg_sync[d] == 0) s = sig[c];
                else if (samp.size() >= cfg_sync[d]) s = samp[samp.size() - cfg_sync[d]][c];
                else s = 0;
                need = (cfg_len[d] > 1) ? cfg_len[d] : 1;
                commit = 0;
                if (s == lvl[d][c]) begin
                    run[d][c] = 0;
                end else begin
                    run[d][c]++;
                    if (run[d][c] >= need) begin
                        commit = 1;
                        lvl[d][c] = s;
                        run[d][c] = 0;
                    end
                end
                pend[d][c] = commit && (lvl[d][c] ? mode[2*c] : mode[2*c+1]);
            end
        end
        if (rst) begin
            samp.delete();
        end else begin
            samp.push_back(sig);
            if (samp.size() > 8) void'(samp.pop_front());
        end
    endtask

    function automatic logic [3:0] exp_pulse(int d);
        logic [3:0] r;
        for (int c = 0; c < 4; c++) r[c] = ep[d][c];
        return r;
    endfunction

    function automatic logic [3:0] exp_sticky(int d);
        logic [3:0] r;
        for (int c = 0; c < 4; c++) r[c] = es[d][c];
        return r;
    endfunction

    function automatic logic [7:0] exp_cnt(int d);
        logic [7:0] r;
        for (int c = 0; c < 4; c++) r[c*2 +: 2] = 2'(ec[d][c]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("a_pulse",  8'(pulse_a),  8'(exp_pulse(0)));
        chk("a_sticky", 8'(sticky_a), 8'(exp_sticky(0)));
        chk("a_cnt",    cnt_a,        exp_cnt(0));
        chk("b_pulse",  8'(pulse_b),  8'(exp_pulse(1)));
        chk("b_sticky", 8'(sticky_b), 8'(exp_sticky(1)));
        chk("b_cnt",    cnt_b,        exp_cnt(1));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int n1;
        int n2;

        // Reset state
        rst = 1'b1;
        steps(2);
        chk("rst_pulse",  8'({pulse_a, pulse_b}),   8'h00);
        chk("rst_sticky", 8'({sticky_a, sticky_b}), 8'h00);
        chk("rst_cnt",    cnt_a | cnt_b,            8'h00);
        rst = 1'b0;

        // Falling-edge mode on A: a rise gives nothing, the fall a single pulse
        mode = 8'hAA;
        sig  = 4'h1;
        steps(3);
        chk("t1_no_rise", 8'(pulse_a[0]), 8'h0);
        sig = 4'h0;
        step();
        chk("t1_commit", 8'(pulse_a[0]), 8'h0);
        step();
        chk("t1_pulse",  8'(pulse_a[0]),  8'h1);
        chk("t1_sticky", 8'(sticky_a[0]), 8'h1);
        step();
        chk("t1_one_cycle",  8'(pulse_a[0]),  8'h0);
        chk("t1_sticky_hold", 8'(sticky_a[0]), 8'h1);
        clr = 4'h1;
        step();
        chk("t1_clr", 8'(sticky_a[0]), 8'h0);
        clr = 4'h0;

        // B debounce: 3-cycle glitch ignored, 5-cycle high gives one rise pulse at +6
        mode = 8'hFF;
        steps(8);
        sig = 4'h1;
        steps(3);
        sig = 4'h0;
        for (int n = 0; n < 10; n++) begin
            step();
            chk("t2_glitch", 8'(pulse_b[0]), 8'h0);
        end
        sig = 4'h1;
        for (int n = 1; n <= 11; n++) begin
            step();
            if (n == 5) sig = 4'h0;
            chk($sformatf("t2_lat_%0d", n), 8'(pulse_b[0]), (n == 7) ? 8'h1 : 8'h0);
        end
        steps(4);

        // Per-channel modes on a common square wave
        mode = 8'b00_10_01_00;
        n1 = 0;
        n2 = 0;
        for (int n = 0; n < 24; n++) begin
            sig = ((n / 3) % 2 == 1) ? 4'hF : 4'h0;
            step();
            chk("t3_off_ch", 8'({pulse_a[3], pulse_a[0], pulse_b[3], pulse_b[0]}), 8'h0);
            n1 += int'(pulse_a[1]);
            n2 += int'(pulse_a[2]);
        end
        chk("t3_rise_cnt", 8'(n1), 8'd4);
        chk("t3_fall_cnt", 8'(n2), 8'd3);

        // Reset during a partial filter count discards the pending edge
        mode = 8'hFF;
        sig  = 4'h0;
        rst  = 1'b1;
        step();
        rst = 1'b0;
        steps(2);
        sig = 4'h1;
        steps(4);
        sig = 4'h0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            chk("t4a_no_pulse", 8'({pulse_a, pulse_b}), 8'h00);
        end

        // Input held high through reset yields one rise pulse after release
        mode = 8'b00_00_01_00;
        sig  = 4'h2;
        rst  = 1'b1;
        steps(2);
        rst = 1'b0;
        n1 = 0;
        n2 = 0;
        for (int n = 0; n < 12; n++) begin
            step();
            n1 += int'(pulse_a[1]);
            n2 += int'(pulse_b[1]);
        end
        chk("t4b_a_rise", 8'(n1), 8'd1);
        chk("t4b_b_rise", 8'(n2), 8'd1);

        // Clear coinciding with the pulse-setting edge leaves sticky set
        mode = 8'h55;
        sig  = 4'h0;
        clr  = 4'hF;
        step();
        clr = 4'h0;
        steps(8);
        chk("t5_cleared", 8'(sticky_a[0]), 8'h0);
        sig = 4'h1;
        step();
        clr = 4'h1;
        step();
        chk("t5_pulse",  8'(pulse_a[0]),  8'h1);
        chk("t5_sticky", 8'(sticky_a[0]), 8'h1);
        clr = 4'h0;
        step();
        chk("t5_sticky_hold", 8'(sticky_a[0]), 8'h1);

        // Counter: saturation, clear, clear with simultaneous event
        mode = 8'hFF;
        sig  = 4'h0;
        steps(8);
        clr = 4'hF;
        step();
        clr = 4'h0;
        chk("t6_zero", 8'(cnt_a[1:0]), 8'h0);
        for (int r = 0; r < 5; r++) begin
            sig = 4'h1;
            steps(2);
            sig = 4'h0;
            steps(2);
        end
        steps(2);
        chk("t6_sat", 8'(cnt_a[1:0]), CntOn ? 8'd3 : 8'd0);
        clr = 4'h1;
        step();
        clr = 4'h0;
        chk("t6_clr", 8'(cnt_a[1:0]), 8'h0);
        sig = 4'h1;
        step();
        clr = 4'h1;
        step();
        clr = 4'h0;
        chk("t6_clr_evt", 8'(cnt_a[1:0]), CntOn ? 8'd1 : 8'd0);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            int lim;
            lim = (n < 200) ? 3 : 7;
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(lim) == 0) sig[c] = ~sig[c];
            end
            if ($urandom_range(19) == 0) mode = 8'($urandom);
            clr = ($urandom_range(7) == 0) ? 4'($urandom) : 4'h0;
            rst = ($urandom_range(99) == 0);
            step();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
